board_support: RTL and testbench
================================

// Module: board_support
// PURPOSE
//  Parametrised board-level conditioning for iCE40 top levels. It combines four functions:
//  power-up reset stretcher, glitch-free clock-enable divider, N-channel button
//  synchroniser/debouncer with press/release pulses, and an RGB status-LED driver.
//  Sits between the oscillator and board pins and the application core (e.g. tv_b_gone).
//  The core runs on clock_in gated by div_tick_out; it never runs on a fabric-divided clock.
// PARAMETERS
//  DIV_RATIO          3      clock_in cycles per div_tick_out pulse; legal >= 2
//  RESET_CYCLES       65536  cycles reset_out stays high after reset_in falls; legal >= 1
//  NUM_BUTTONS        1      number of button channels; legal >= 1
//  BUTTON_ACTIVE_LOW  1      1: raw pin low = pressed
//  DEBOUNCE_CYCLES    16000  consecutive stable cycles needed to accept a change; legal >= 2
//  BLINK_CYCLES       4000000 cycles per blink half-period
//  LED_ACTIVE_LOW     1      1: led_rgb_out drives 0 to light
// PORTS
//  clock_in            in   1            single system clock
//  reset_in            in   1            synchronous, active-high reset
//  buttons_in          in   NUM_BUTTONS  raw asynchronous button pins
//  status_mode_in      in   2            0 idle, 1 busy, 2 fail, 3 done
//  reset_out           out  1            stretched synchronous reset for the core, active-high
//  div_tick_out        out  1            1-cycle enable, period DIV_RATIO
//  button_level_out    out  NUM_BUTTONS  debounced level, 1 = pressed
//  button_press_out    out  NUM_BUTTONS  1-cycle pulse on accepted press
//  button_release_out  out  NUM_BUTTONS  1-cycle pulse on accepted release
//  led_rgb_out         out  3            {red,green,blue}, registered, polarity per LED_ACTIVE_LOW
// BEHAVIOUR
//  Reset (reset_in high at an edge) clears all counters and registers:
//   - reset_out=1, div_tick_out=0, level/press/release=0.
//   - LEDs off: 3'b111 if LED_ACTIVE_LOW, otherwise 3'b000.
//  Reset stretcher:
//   - Counter starts at the first edge with reset_in low.
//   - reset_out falls exactly RESET_CYCLES edges after reset_in deasserts.
//   - reset_in re-asserting mid-count restarts the full count.
//  Divider:
//   - Counts 0..DIV_RATIO-1, held at 0 while reset_out=1.
//   - div_tick_out=1 for the single cycle with count==DIV_RATIO-1.
//   - First tick is DIV_RATIO cycles after reset_out falls; spacing is exactly DIV_RATIO thereafter.
//   - Output is registered and never glitches.
//  Buttons (per channel, independent):
//   - 2-flop synchroniser, then polarity normalise so pressed = 1.
//   - While reset_out=1, counter is held 0 and level is held 0.
//   - If sample != level, the counter increments. If sample == level, the counter clears to 0.
//   - When the counter reaches DEBOUNCE_CYCLES-1 with sample still != level:
//       * level toggles and the counter clears;
//       * press (0->1) or release (1->0) pulses for exactly one cycle, aligned with the level change.
//   - Latency from a clean raw edge to the level change is DEBOUNCE_CYCLES+2 edges.
//   - A glitch shorter than DEBOUNCE_CYCLES samples produces no change.
//   - A button already pressed at reset release yields one press pulse after the debounce period.
//  LED driver:
//   - Blink phase flips every BLINK_CYCLES cycles; it is forced to "on" during reset.
//   - Modes:
//       * idle: all off.
//       * busy: green follows blink phase.
//       * fail: red solid.
//       * done: blue solid.
//   - Mode change is reflected on the next edge; it does not reset the blink phase.
//   - Counters wrap naturally; no saturation.
// TESTING (DIV_RATIO=3, RESET_CYCLES=8, DEBOUNCE_CYCLES=4, BLINK_CYCLES=5, NUM_BUTTONS=2, active-low)
//  1. Release reset_in at edge 0 -> reset_out low from edge 8; div_tick_out high at edges 11,14,17.
//  2. Re-assert reset_in for 1 cycle at edge 5 of stretch -> reset_out stays high until 8 edges after
//     the new release; no div_tick_out pulse during stretch.
//  3. buttons_in[0] 1->0 held -> button_level_out[0]=1 and button_press_out[0] one-cycle pulse at
//     edge +6; release -> release pulse at +6; channel 1 untouched.
//  4. buttons_in[1] low for 3 cycles then high -> no level change, no pulses on either channel.
//  5. Both buttons pressed on the same edge -> both press pulses on the same cycle.
//  6. status_mode_in=1 -> green toggles every 5 cycles, red/blue 1. Mode=2 -> next edge gives
//     led_rgb_out=3'b011. Reset_in -> 3'b111.

Source files
------------

// File: rtl/board_support.sv
// Board-level conditioning: reset stretcher, clock-enable divider,
// button debouncer with press/release pulses and RGB status LED driver.
//
// Ports:
//   clock_in           - single system clock
//   reset_in           - synchronous active-high reset
//   buttons_in         - raw asynchronous button pins
//   status_mode_in     - 0 idle, 1 busy, 2 fail, 3 done
//   reset_out          - stretched active-high reset for the core
//   div_tick_out       - 1-cycle clock enable every DIV_RATIO cycles
//   button_level_out   - debounced level, 1 = pressed
//   button_press_out   - 1-cycle pulse on accepted press
//   button_release_out - 1-cycle pulse on accepted release
//   led_rgb_out        - registered {red,green,blue} drive
module board_support #(
    parameter int DIV_RATIO         = 3,
    parameter int RESET_CYCLES      = 65536,
    parameter int NUM_BUTTONS       = 1,
    parameter int BUTTON_ACTIVE_LOW = 1,
    parameter int DEBOUNCE_CYCLES   = 16000,
    parameter int BLINK_CYCLES      = 4000000,
    parameter int LED_ACTIVE_LOW    = 1
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic [NUM_BUTTONS-1:0] buttons_in,
    input  logic [1:0]             status_mode_in,
    output logic                   reset_out,
    output logic                   div_tick_out,
    output logic [NUM_BUTTONS-1:0] button_level_out,
    output logic [NUM_BUTTONS-1:0] button_press_out,
    output logic [NUM_BUTTONS-1:0] button_release_out,
    output logic [2:0]             led_rgb_out
);

    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int DW = $clog2(DIV_RATIO);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam int LW = $clog2(BLINK_CYCLES + 1);

    localparam logic [RW-1:0] RST_END  = RW'(RESET_CYCLES);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_RATIO - 1);
    localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] BLK_LAST = LW'(BLINK_CYCLES - 1);

    localparam logic [NUM_BUTTONS-1:0] BTN_POL =
        {NUM_BUTTONS{BUTTON_ACTIVE_LOW != 0}};
    localparam logic [2:0] LED_POL = {3{LED_ACTIVE_LOW != 0}};

    // ---------------- reset stretcher ----------------
    logic [RW-1:0] rst_cnt;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            rst_cnt   <= '0;
            reset_out <= 1'b1;
        end else if (reset_out) begin
            if (rst_cnt == RST_END) begin
                reset_out <= 1'b0;
            end else begin
                rst_cnt <= rst_cnt + 1'b1;
            end
        end
    end

    // ---------------- clock-enable divider ----------------
    logic [DW-1:0] div_cnt;

    always_ff @(posedge clock_in) begin
        if (reset_in || reset_out) begin
            div_cnt      <= '0;
            div_tick_out <= 1'b0;
        end else begin
            div_tick_out <= (div_cnt == DIV_LAST);
            div_cnt      <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        end
    end

    // ---------------- button debouncers ----------------
    // Polarity is normalised before the synchroniser so its reset
    // value reads as "not pressed" regardless of pin polarity.
    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= buttons_in ^ BTN_POL;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        logic [BW-1:0] db_cnt;
        logic          differs;

        assign differs = sync2[i] != button_level_out[i];

        always_ff @(posedge clock_in) begin
            if (reset_in || reset_out) begin
                db_cnt                <= '0;
                button_level_out[i]   <= 1'b0;
                button_press_out[i]   <= 1'b0;
                button_release_out[i] <= 1'b0;
            end else begin
                button_press_out[i]   <= 1'b0;
                button_release_out[i] <= 1'b0;
                if (!differs) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt                <= '0;
                    button_level_out[i]   <= sync2[i];
                    button_press_out[i]   <= sync2[i];
                    button_release_out[i] <= !sync2[i];
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- status LED ----------------
    logic [LW-1:0] blk_cnt;
    logic          blink_on;
    logic [2:0]    led_on;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            blk_cnt  <= '0;
            blink_on <= 1'b1;
        end else if (blk_cnt == BLK_LAST) begin
            blk_cnt  <= '0;
            blink_on <= !blink_on;
        end else begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    always_comb begin
        led_on = 3'b000;
        unique case (status_mode_in)
            2'd0: led_on = 3'b000;
            2'd1: led_on = {1'b0, blink_on, 1'b0};
            2'd2: led_on = 3'b100;
            2'd3: led_on = 3'b001;
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            led_rgb_out <= LED_POL;
        end else begin
            led_rgb_out <= led_on ^ LED_POL;
        end
    end

endmodule

// File: tb/tb_board_support.sv
// Self-checking bench for board_support: directed scenarios followed by
// randomized button/mode/reset stimulus, checked every cycle against a model.
module tb_board_support;

    localparam int DIV = 3;
    localparam int RST = 8;
    localparam int DEB = 4;
    localparam int BLK = 5;
    localparam int NB  = 2;

    logic          clk = 1'b0;
    logic          rst_in;
    logic [NB-1:0] btn;
    logic [1:0]    mode;
    logic          rst_out;
    logic          tick;
    logic [NB-1:0] level;
    logic [NB-1:0] press;
    logic [NB-1:0] release_p;
    logic [2:0]    led;

    always #5 clk = ~clk;

    board_support #(
        .DIV_RATIO(DIV),
        .RESET_CYCLES(RST),
        .NUM_BUTTONS(NB),
        .BUTTON_ACTIVE_LOW(1),
        .DEBOUNCE_CYCLES(DEB),
        .BLINK_CYCLES(BLK),
        .LED_ACTIVE_LOW(1)
    ) dut (
        .clock_in(clk),
        .reset_in(rst_in),
        .buttons_in(btn),
        .status_mode_in(mode),
        .reset_out(rst_out),
        .div_tick_out(tick),
        .button_level_out(level),
        .button_press_out(press),
        .button_release_out(release_p),
        .led_rgb_out(led)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model. k counts edges since reset_in was last low-sampled
    // (first low edge is k=0); bk does the same for the blink timebase.
    int            k  = -1;
    int            bk = 0;
    int            run [NB];
    logic [NB-1:0] p1, p2, m_lvl, m_prs, m_rel;
    logic          m_ro, m_tick;
    logic [2:0]    m_led;

    task automatic model_edge();
        logic       prev_ro;
        logic       phase;
        logic [2:0] on;
        prev_ro = m_ro;
        if (rst_in) begin
            k      = -1;
            bk     = 0;
            m_ro   = 1'b1;
            m_tick = 1'b0;
            p1     = '0;
            p2     = '0;
            m_lvl  = '0;
            m_prs  = '0;
            m_rel  = '0;
            for (int i = 0; i < NB; i++) run[i] = 0;
            m_led  = 3'b111;
        end else begin
            k++;
            m_ro   = (k < RST);
            m_tick = (k > RST) && ((k - RST) % DIV == 0);
            m_prs  = '0;
            m_rel  = '0;
            for (int i = 0; i < NB; i++) begin
                if (prev_ro) begin
                    run[i]   = 0;
                    m_lvl[i] = 1'b0;
                end else if (p2[i] != m_lvl[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        run[i]   = 0;
                        m_lvl[i] = p2[i];
                        m_prs[i] = p2[i];
                        m_rel[i] = !p2[i];
                    end
                end else begin
                    run[i] = 0;
                end
            end
            p2 = p1;
            p1 = ~btn;
            phase = ((bk / BLK) % 2) == 0;
            case (mode)
                2'd0: on = 3'b000;
                2'd1: on = {1'b0, phase, 1'b0};
                2'd2: on = 3'b100;
                default: on = 3'b001;
            endcase
            m_led = ~on;
            bk++;
        end
    endtask

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            check("reset_out", 32'(rst_out), 32'(m_ro));
            check("div_tick", 32'(tick), 32'(m_tick));
            check("level", 32'(level), 32'(m_lvl));
            check("press", 32'(press), 32'(m_prs));
            check("release", 32'(release_p), 32'(m_rel));
            check("led", 32'(led), 32'(m_led));
        end
    endtask

    initial begin
        rst_in = 1'b1;
        btn    = '1;
        mode   = 2'd0;
        m_ro   = 1'b1;
        step(3);

        // stretch then steady ticks
        rst_in = 1'b0;
        step(20);

        // reset pulse mid-stretch restarts the count
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
        step(5);
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
        step(15);

        // channel 0 press and release
        btn[0] = 1'b0;
        step(12);
        btn[0] = 1'b1;
        step(12);

        // 3-cycle glitch on channel 1
        btn[1] = 1'b0;
        step(3);
        btn[1] = 1'b1;
        step(10);

        // simultaneous press on both channels, then release
        btn = 2'b00;
        step(10);
        btn = 2'b11;
        step(10);

        // LED modes
        mode = 2'd1;
        step(15);
        mode = 2'd2;
        step(2);
        mode = 2'd3;
        step(2);
        rst_in = 1'b1;
        step(1);
        rst_in = 1'b0;
        mode = 2'd1;
        step(12);

        // button held at reset release -> press after debounce
        btn[1] = 1'b0;
        rst_in = 1'b1;
        step(2);
        rst_in = 1'b0;
        step(20);
        btn[1] = 1'b1;
        step(10);

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(5) == 0) btn[i] = ~btn[i];
            end
            if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
            rst_in = ($urandom_range(599) == 0);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
